// File: rtl/dmem_wbuf_if.sv
// Line-bus bundle between L1 data cache, the write-through buffer and L2.
// slave is the buffer's view; master is the L1/L2 environment's view.
interface dmem_wbuf_if #(parameter int LINE = 512);
    logic [63:0]     l1_addr;
    logic            l1_rd;
    logic [LINE-1:0] l1_data_out;
    logic            l1_dv;
    logic [LINE-1:0] l1_data_in;
    logic            l1_wr;
    logic            l1_full;
    logic            wb_empty;
    logic            ovf;
    logic [63:0]     l2_addr;
    logic            l2_rd;
    logic            l2_wr;
    logic [LINE-1:0] l2_data_out;
    logic [LINE-1:0] l2_data_in;
    logic            l2_ack;

    modport slave (
        input  l1_addr, l1_rd, l1_data_in, l1_wr, l2_data_in, l2_ack,
        output l1_data_out, l1_dv, l1_full, wb_empty, ovf,
               l2_addr, l2_rd, l2_wr, l2_data_out
    );

    modport master (
        output l1_addr, l1_rd, l1_data_in, l1_wr, l2_data_in, l2_ack,
        input  l1_data_out, l1_dv, l1_full, wb_empty, ovf,
               l2_addr, l2_rd, l2_wr, l2_data_out
    );
endinterface

// File: rtl/dmem_wbuf.sv
// Write-through buffer with coalescing, RAW forwarding of L1 refills and
// an L2 request sequencer that drains queued lines when no read is pending.
//
//   state | meaning
//   IDLE  | choose: forward hit, L2 read, or drain head
//   RD    | L2 read outstanding, waiting for l2_ack
//   FWD   | l1_dv pulse with line forwarded from buffer
//   DV    | l1_dv pulse with line returned by L2
//   WR    | head line being written to L2, waiting for l2_ack
//   HOLD  | wait for L1 to drop l1_rd
module dmem_wbuf #(
    parameter int LINE  = 512,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        clr,
    dmem_wbuf_if.slave  bus
);
    localparam int OFFS = $clog2(LINE / 8);
    localparam int TAGW = 64 - OFFS;
    localparam int PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, RD, FWD, DV, WR, HOLD} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PW:0]       count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TAGW-1:0]   tag_q  [DEPTH];
    logic [TAGW-1:0]   tag_d  [DEPTH];
    logic [LINE-1:0]   data_q [DEPTH];
    logic [LINE-1:0]   data_d [DEPTH];
    logic [63:0]       l2_addr_q, l2_addr_d;
    logic [LINE-1:0]   l1_data_out_q, l1_data_out_d;
    logic [LINE-1:0]   l2_data_out_q, l2_data_out_d;
    logic              l1_full_q, l1_full_d;
    logic              ovf_q, ovf_d;

    logic [TAGW-1:0]   l1_tag;
    logic [DEPTH-1:0]  match_vec, coal_vec;
    logic              fwd_hit, coal_hit, head_busy, push, pop;
    logic [PW-1:0]     scan_idx;
    logic [LINE-1:0]   fwd_data;

    assign l1_tag = bus.l1_addr[63:OFFS];

    // Scan oldest to youngest so the last hit is the youngest copy of the line.
    always_comb begin
        match_vec = '0;
        fwd_data  = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid_q[i] && (tag_q[i] == l1_tag);
        end
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PW'(k);
            if (match_vec[scan_idx]) begin
                fwd_data = data_q[scan_idx];
            end
        end
        fwd_hit = |match_vec;
    end

    always_comb begin
        state_d       = state_q;
        l2_addr_d     = l2_addr_q;
        l1_data_out_d = l1_data_out_q;
        l2_data_out_d = l2_data_out_q;
        pop           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.l1_rd && fwd_hit) begin
                    state_d       = FWD;
                    l1_data_out_d = fwd_data;
                end else if (bus.l1_rd) begin
                    state_d   = RD;
                    l2_addr_d = {l1_tag, {OFFS{1'b0}}};
                end else if (count_q != '0) begin
                    state_d       = WR;
                    l2_addr_d     = {tag_q[head_q], {OFFS{1'b0}}};
                    l2_data_out_d = data_q[head_q];
                end
            end
            RD: begin
                if (bus.l2_ack) begin
                    l1_data_out_d = bus.l2_data_in;
                    state_d       = DV;
                end
            end
            FWD, DV: state_d = HOLD;
            HOLD: begin
                if (!bus.l1_rd) state_d = IDLE;
            end
            WR: begin
                if (bus.l2_ack) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The head is frozen from the edge that launches its L2 write, otherwise a
    // coalesced update would be popped without ever reaching L2.
    always_comb begin
        head_busy = (state_q == WR) || (state_q == IDLE && state_d == WR);
        coal_vec  = match_vec;
        if (head_busy) coal_vec[head_q] = 1'b0;
        coal_hit  = |coal_vec;

        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        ovf_d   = ovf_q;
        push    = 1'b0;

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (bus.l1_wr) begin
            if (coal_hit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (coal_vec[i]) data_d[i] = bus.l1_data_in;
                end
            end else if (count_q != FULL_CNT || pop) begin
                push            = 1'b1;
                tag_d[tail_q]   = l1_tag;
                data_d[tail_q]  = bus.l1_data_in;
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        count_d   = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        l1_full_d = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            tag_q         <= '{default: '0};
            data_q        <= '{default: '0};
            l2_addr_q     <= '0;
            l1_data_out_q <= '0;
            l2_data_out_q <= '0;
            l1_full_q     <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            data_q        <= data_d;
            l2_addr_q     <= l2_addr_d;
            l1_data_out_q <= l1_data_out_d;
            l2_data_out_q <= l2_data_out_d;
            l1_full_q     <= l1_full_d;
            ovf_q         <= ovf_d;
        end
    end

    assign bus.l1_data_out = l1_data_out_q;
    assign bus.l1_dv       = (state_q == FWD) || (state_q == DV);
    assign bus.l1_full     = l1_full_q;
    assign bus.wb_empty    = (count_q == '0) && (state_q != WR);
    assign bus.ovf         = ovf_q;
    assign bus.l2_addr     = l2_addr_q;
    assign bus.l2_rd       = (state_q == RD);
    assign bus.l2_wr       = (state_q == WR);
    assign bus.l2_data_out = l2_data_out_q;
endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: L2 refill, forwarding, coalescing, overflow,
// in-flight head protection, same-cycle read/write and mid-write reset.
module tb_dmem_wbuf;
    localparam int LINE = 512;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    dmem_wbuf_if #(.LINE(LINE)) bus ();
    dmem_wbuf #(.LINE(LINE), .DEPTH(4)) dut (.clk(clk), .clr(clr), .bus(bus));

    int passed = 0;
    int total  = 0;

    function automatic logic [LINE-1:0] pat(input logic [31:0] x);
        return {16{x}};
    endfunction

    task automatic write_line(input logic [63:0] a, input logic [LINE-1:0] d);
        bus.l1_addr    = a;
        bus.l1_data_in = d;
        bus.l1_wr      = 1'b1;
        @(negedge clk);
        bus.l1_wr      = 1'b0;
    endtask

    task automatic open_read(input logic [63:0] a);
        bus.l1_addr = a;
        bus.l1_rd   = 1'b1;
        @(negedge clk);
    endtask

    task automatic close_read(input string nm, input logic [LINE-1:0] d);
        bus.l2_data_in = d;
        bus.l2_ack     = 1'b1;
        @(negedge clk);
        bus.l2_ack     = 1'b0;
        total++;
        if (bus.l1_dv !== 1'b1 || bus.l1_data_out !== d)
            $display("FAIL %s dv=%b data=%h, expected dv=1 data=%h", nm, bus.l1_dv, bus.l1_data_out, d);
        else passed++;
        bus.l1_rd = 1'b0;
    endtask

    task automatic drain_one(input string nm, input logic [63:0] a, input logic [LINE-1:0] d);
        int n = 0;
        while (bus.l2_wr !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.l2_wr !== 1'b1)
            $display("FAIL %s l2_wr=%b after %0d cycles, expected 1", nm, bus.l2_wr, n);
        else if (bus.l2_addr !== a || bus.l2_data_out !== d)
            $display("FAIL %s addr=%h data=%h, expected addr=%h data=%h", nm, bus.l2_addr, bus.l2_data_out, a, d);
        else passed++;
        bus.l2_ack = 1'b1;
        @(negedge clk);
        bus.l2_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        total++;
        if ({bus.l1_dv, bus.l2_rd, bus.l2_wr, bus.l1_full, bus.ovf, bus.wb_empty} !== 6'b000001)
            $display("FAIL %s flags dv,rd,wr,full,ovf,empty=%b%b%b%b%b%b, expected 000001", nm,
                     bus.l1_dv, bus.l2_rd, bus.l2_wr, bus.l1_full, bus.ovf, bus.wb_empty);
        else passed++;
        total++;
        if (bus.l2_addr !== 64'h0 || bus.l1_data_out !== '0 || bus.l2_data_out !== '0)
            $display("FAIL %s l2_addr=%h l1_data_out=%h l2_data_out=%h, expected all 0", nm,
                     bus.l2_addr, bus.l1_data_out[63:0], bus.l2_data_out[63:0]);
        else passed++;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        clr = 1'b0;
    endtask

    task automatic test_l2_read();
        open_read(64'h1000);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (bus.l2_rd !== 1'b1 || bus.l2_addr !== 64'h1000 || bus.l1_dv !== 1'b0)
                $display("FAIL l2_read_req cycle %0d rd=%b addr=%h dv=%b, expected rd=1 addr=1000 dv=0",
                         c, bus.l2_rd, bus.l2_addr, bus.l1_dv);
            else passed++;
            if (c == 2) begin
                bus.l2_data_in = pat(32'hA5A5_0001);
                bus.l2_ack     = 1'b1;
            end
            @(negedge clk);
        end
        bus.l2_ack = 1'b0;
        total++;
        if (bus.l1_dv !== 1'b1 || bus.l1_data_out !== pat(32'hA5A5_0001) || bus.l2_rd !== 1'b0)
            $display("FAIL l2_read_dv dv=%b rd=%b data=%h, expected dv=1 rd=0 data=A", bus.l1_dv, bus.l2_rd, bus.l1_data_out);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (bus.l1_dv !== 1'b0 || bus.l2_rd !== 1'b0)
                $display("FAIL l2_read_hold cycle %0d dv=%b rd=%b, expected 0 0", c, bus.l1_dv, bus.l2_rd);
            else passed++;
        end
        bus.l1_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_forward();
        write_line(64'h2000, pat(32'hBBBB_0002));
        total++;
        if (bus.wb_empty !== 1'b0)
            $display("FAIL fwd_queued wb_empty=%b, expected 0", bus.wb_empty);
        else passed++;
        bus.l1_addr = 64'h2000;
        bus.l1_rd   = 1'b1;
        @(negedge clk);
        total++;
        if (bus.l1_dv !== 1'b1 || bus.l1_data_out !== pat(32'hBBBB_0002) || bus.l2_rd !== 1'b0 || bus.l2_wr !== 1'b0)
            $display("FAIL fwd_hit dv=%b rd=%b wr=%b data=%h, expected dv=1 rd=0 wr=0 data=B",
                     bus.l1_dv, bus.l2_rd, bus.l2_wr, bus.l1_data_out);
        else passed++;
        bus.l1_rd = 1'b0;
        @(negedge clk);
        total++;
        if (bus.l1_dv !== 1'b0)
            $display("FAIL fwd_pulse dv=%b, expected 0", bus.l1_dv);
        else passed++;
        drain_one("fwd_drain", 64'h2000, pat(32'hBBBB_0002));
        total++;
        if (bus.wb_empty !== 1'b1)
            $display("FAIL fwd_empty wb_empty=%b, expected 1", bus.wb_empty);
        else passed++;
    endtask

    task automatic test_coalesce();
        open_read(64'h9000);
        write_line(64'h3000, pat(32'hCCCC_0003));
        write_line(64'h3040, pat(32'hDDDD_0004));
        write_line(64'h3000, pat(32'hEEEE_0005));
        total++;
        if (bus.l2_rd !== 1'b1 || bus.l2_addr !== 64'h9000 || bus.l1_full !== 1'b0 || bus.wb_empty !== 1'b0)
            $display("FAIL coal_stall rd=%b addr=%h full=%b empty=%b, expected 1 9000 0 0",
                     bus.l2_rd, bus.l2_addr, bus.l1_full, bus.wb_empty);
        else passed++;
        close_read("coal_read", pat(32'h9999_0009));
        drain_one("coal_drain0", 64'h3000, pat(32'hEEEE_0005));
        drain_one("coal_drain1", 64'h3040, pat(32'hDDDD_0004));
        total++;
        if (bus.wb_empty !== 1'b1)
            $display("FAIL coal_count wb_empty=%b, expected 1 after two drains", bus.wb_empty);
        else passed++;
    endtask

    task automatic test_full();
        int n;
        open_read(64'h9000);
        for (int i = 0; i < 4; i++) begin
            write_line(64'h7000 + 64'(i * 64), pat(32'h7000_0000 + 32'(i)));
            total++;
            if (bus.l1_full !== (i == 3))
                $display("FAIL full_fill%0d l1_full=%b, expected %b", i, bus.l1_full, (i == 3));
            else passed++;
        end
        write_line(64'h7100, pat(32'h7000_00FF));
        total++;
        if (bus.l1_full !== 1'b1 || bus.ovf !== 1'b1)
            $display("FAIL full_drop full=%b ovf=%b, expected 1 1", bus.l1_full, bus.ovf);
        else passed++;
        close_read("full_read", pat(32'h9999_0019));
        for (int i = 0; i < 4; i++)
            drain_one("full_drain", 64'h7000 + 64'(i * 64), pat(32'h7000_0000 + 32'(i)));
        total++;
        if (bus.wb_empty !== 1'b1 || bus.ovf !== 1'b1 || bus.l1_full !== 1'b0)
            $display("FAIL full_sticky empty=%b ovf=%b full=%b, expected 1 1 0", bus.wb_empty, bus.ovf, bus.l1_full);
        else passed++;

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        open_read(64'h9000);
        for (int i = 0; i < 4; i++)
            write_line(64'h7200 + 64'(i * 64), pat(32'h7200_0000 + 32'(i)));
        close_read("pop_push_read", pat(32'h9999_0029));
        n = 0;
        while (bus.l2_wr !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.l2_wr !== 1'b1 || bus.l2_addr !== 64'h7200)
            $display("FAIL pop_push_head wr=%b addr=%h, expected 1 7200", bus.l2_wr, bus.l2_addr);
        else passed++;
        bus.l2_ack     = 1'b1;
        bus.l1_addr    = 64'h7300;
        bus.l1_data_in = pat(32'h7200_0004);
        bus.l1_wr      = 1'b1;
        @(negedge clk);
        bus.l2_ack = 1'b0;
        bus.l1_wr  = 1'b0;
        total++;
        if (bus.ovf !== 1'b0 || bus.l1_full !== 1'b1)
            $display("FAIL pop_push ovf=%b full=%b, expected 0 1", bus.ovf, bus.l1_full);
        else passed++;
        for (int i = 1; i < 4; i++)
            drain_one("pop_push_drain", 64'h7200 + 64'(i * 64), pat(32'h7200_0000 + 32'(i)));
        drain_one("pop_push_new", 64'h7300, pat(32'h7200_0004));
        total++;
        if (bus.wb_empty !== 1'b1 || bus.ovf !== 1'b0)
            $display("FAIL pop_push_end empty=%b ovf=%b, expected 1 0", bus.wb_empty, bus.ovf);
        else passed++;
    endtask

    task automatic test_inflight();
        int n = 0;
        write_line(64'h4000, pat(32'hF0F0_0006));
        while (bus.l2_wr !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.l1_addr    = 64'h4000;
        bus.l1_data_in = pat(32'h6060_0007);
        bus.l1_wr      = 1'b1;
        @(negedge clk);
        bus.l1_wr = 1'b0;
        total++;
        if (bus.l2_wr !== 1'b1 || bus.l2_addr !== 64'h4000 || bus.l2_data_out !== pat(32'hF0F0_0006))
            $display("FAIL inflight_head wr=%b addr=%h data=%h, expected 1 4000 F",
                     bus.l2_wr, bus.l2_addr, bus.l2_data_out);
        else passed++;
        bus.l2_ack = 1'b1;
        @(negedge clk);
        bus.l2_ack = 1'b0;
        drain_one("inflight_second", 64'h4000, pat(32'h6060_0007));
        total++;
        if (bus.wb_empty !== 1'b1)
            $display("FAIL inflight_empty wb_empty=%b, expected 1", bus.wb_empty);
        else passed++;
    endtask

    task automatic test_same_cycle();
        bus.l1_addr    = 64'h6000;
        bus.l1_data_in = pat(32'h5A5A_0008);
        bus.l1_wr      = 1'b1;
        bus.l1_rd      = 1'b1;
        @(negedge clk);
        bus.l1_wr = 1'b0;
        total++;
        if (bus.l2_rd !== 1'b1 || bus.l2_addr !== 64'h6000 || bus.l1_dv !== 1'b0)
            $display("FAIL same_cycle rd=%b addr=%h dv=%b, expected 1 6000 0", bus.l2_rd, bus.l2_addr, bus.l1_dv);
        else passed++;
        close_read("same_cycle_read", pat(32'h1212_0010));
        drain_one("same_cycle_drain", 64'h6000, pat(32'h5A5A_0008));
    endtask

    task automatic test_clr_mid();
        int n = 0;
        write_line(64'h5000, pat(32'h4848_0011));
        while (bus.l2_wr !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.l2_wr !== 1'b1)
            $display("FAIL clr_mid_start l2_wr=%b, expected 1", bus.l2_wr);
        else passed++;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_reset_outputs("clr_mid");
        bus.l2_ack = 1'b1;
        @(negedge clk);
        bus.l2_ack = 1'b0;
        total++;
        if ({bus.l2_wr, bus.l2_rd, bus.wb_empty, bus.l1_dv, bus.l1_full} !== 5'b00100)
            $display("FAIL clr_stale_ack wr,rd,empty,dv,full=%b%b%b%b%b, expected 00100",
                     bus.l2_wr, bus.l2_rd, bus.wb_empty, bus.l1_dv, bus.l1_full);
        else passed++;
        write_line(64'h5040, pat(32'h4848_0012));
        drain_one("clr_after", 64'h5040, pat(32'h4848_0012));
        total++;
        if (bus.wb_empty !== 1'b1)
            $display("FAIL clr_after_empty wb_empty=%b, expected 1", bus.wb_empty);
        else passed++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.l1_addr    = '0;
        bus.l1_rd      = 1'b0;
        bus.l1_data_in = '0;
        bus.l1_wr      = 1'b0;
        bus.l2_data_in = '0;
        bus.l2_ack     = 1'b0;
        test_reset();
        test_l2_read();
        test_forward();
        test_coalesce();
        test_full();
        test_inflight();
        test_same_cycle();
        test_clr_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Write-through buffer and L2 request sequencer between the L1 data cache line-bus side and the L2 cache.
- Queues full-line write-throughs from L1 and coalesces repeat writes to the same line.
- Serves L1 refill reads, forwarding from the buffer on a line-address match (RAW safety) and otherwise issuing an L2 read.
- Drains queued writes to L2 whenever no read is pending.

Parameters:
- LINE, 512, cache line width in bits; must equal the L1 line size; OFFS = log2(LINE/8).
- DEPTH, 4, write-buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- clr  in  1  synchronous reset, active-high
- l1_addr  in  64  line-aligned address from L1, bits [OFFS-1:0] ignored
- l1_rd  in  1  level refill request; held until after l1_dv
- l1_data_out  out  LINE  refill line to L1
- l1_dv  out  1  one-cycle pulse, l1_data_out valid
- l1_data_in  in  LINE  write-through line from L1
- l1_wr  in  1  one-cycle write-through pulse
- l1_full  out  1  no free entry
- wb_empty  out  1  buffer empty and no L2 write in flight (fence support)
- ovf  out  1  sticky; a write was dropped
- l2_addr  out  64  L2 request address, line-aligned
- l2_rd  out  1  L2 read request, held until l2_ack
- l2_wr  out  1  L2 write request, held until l2_ack
- l2_data_out  out  LINE  write line to L2
- l2_data_in  in  LINE  read line from L2, valid with l2_ack
- l2_ack  in  1  one-cycle completion pulse from L2

Behaviour:
- Reset (clr sampled high at a clock edge):
  - l1_dv = l2_rd = l2_wr = l1_full = ovf = 0; wb_empty = 1.
  - l2_addr = l1_data_out = l2_data_out = 0.
  - FIFO emptied and state set to IDLE.
  - Reset mid-transaction abandons it; a later l2_ack is ignored.
- Line match: compare l1_addr[63:OFFS] against each valid entry.
- Enqueue, on every edge where l1_wr = 1, in any state:
  - A match exists on an entry that is not the in-flight head: overwrite that entry's data in place. No new entry; succeeds even when full.
  - No such match, and not full: write the tail entry and advance the tail.
  - Full, no match, and no pop on the same edge: drop the write and set ovf. ovf clears only on clr.
  - Same-edge pop (l2_ack in WR) and push while full: accepted.
- l1_full is registered and reflects the count after the edge.
- FSM states: IDLE, RD, FWD, DV, WR, HOLD.
- IDLE, priority read over drain:
  - l1_rd = 1 and a match exists in the registered buffer contents: go to FWD; latch the youngest matching entry's data into l1_data_out.
  - l1_rd = 1, no match: go to RD; l2_addr = {l1_addr[63:OFFS], 0}; l2_rd = 1.
  - Else, buffer not empty: go to WR; l2_addr = head address; l2_data_out = head data; l2_wr = 1.
- RD: hold l2_rd and l2_addr. On l2_ack: l1_data_out <= l2_data_in, l2_rd <= 0, go to DV.
- FWD and DV: l1_dv = 1 for exactly this one cycle, then go to HOLD.
- HOLD: stay until l1_rd = 0, then go to IDLE. This prevents a duplicate refill while L1 lowers its request.
- WR:
  - Hold l2_wr, l2_addr and l2_data_out stable; the in-flight head is never coalesced.
  - On l2_ack: pop the head, l2_wr <= 0, go to IDLE.
  - A read arriving during WR waits until WR completes.
- Latency:
  - Forward hit: l1_rd seen in IDLE at edge N, so l1_dv is high in cycle N+1.
  - L2 read: l2_rd is high from cycle N+1; l2_ack at edge M gives l1_dv in cycle M+1.
- Same-cycle l1_wr and l1_rd to the same line in IDLE:
  - The write enqueues at edge N, and the read's match search at edge N sees the old contents.
  - The read therefore goes to L2, since L1 already holds the merged line.
- FIFO pointers are log2(DEPTH) bits, wrap modulo DEPTH, with a separate count of width log2(DEPTH)+1.
- wb_empty = (count == 0) and state != WR.

Test Plan:
- Reset then l1_rd at addr 0x1000, l2_ack 3 cycles later with data pattern A → l2_rd high for 3 cycles with l2_addr = 0x1000; l1_dv 1-cycle pulse carrying A; l2_rd and l1_dv drop; FSM holds until l1_rd falls.
- Write 0x2000 line B, then l1_rd 0x2000 before drain → l1_dv one cycle after the request with B; no l2_rd issued.
- Writes 0x3000 (C), 0x3040 (D), 0x3000 (E), stalled L2 → count = 2; drain order is 0x3000 with E, then 0x3040 with D.
- Fill 4 distinct lines, L2 stalled, 5th distinct write → l1_full = 1, ovf = 1 (sticky), 5th line never appears on L2. Next, repeat the fill with a 5th write on the l2_ack edge of the head → accepted, ovf stays 0.
- l1_wr to the in-flight head line 0x4000 during WR → new entry created; head data on l2_data_out unchanged; second write of 0x4000 follows.
- clr asserted while l2_wr is high mid-WR, stale l2_ack afterward → next cycle all outputs at reset values, wb_empty = 1; the ack causes no pop or state change.
